id_alu_issue: RTL and testbench

- Decode-side producer for the EX-stage ALU.
- Accepts one RV32I integer instruction per cycle with its register-file operands and decodes it into a 4-bit ALU op plus A/B operands.
- Holds the result in a single valid/ready pipeline register feeding EX, with stall and flush support.
- Covers OP, OP-IMM, LUI and AUIPC. All other instructions are flagged illegal.

---
 rtl/id_alu_issue.sv | 184 ++++++++++++++++++
 tb/tb_id_alu_issue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : id_alu_issue
// Purpose : Decodes RV32I OP/OP-IMM/LUI/AUIPC into an ALU request held in a
//           single valid/ready register feeding EX, with stall and flush.
// Revision: 1.0  initial release
// ============================================================================
module id_alu_issue #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [4:0]       rd,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [3:0] c_ALU_ADD = 4'd0;
  localparam logic [3:0] c_ALU_SUB = 4'd1;
  localparam logic [3:0] c_ALU_SLL = 4'd2;
  localparam logic [3:0] c_ALU_XOR = 4'd3;
  localparam logic [3:0] c_ALU_SRL = 4'd4;
  localparam logic [3:0] c_ALU_SRA = 4'd5;
  localparam logic [3:0] c_ALU_OR  = 4'd6;
  localparam logic [3:0] c_ALU_AND = 4'd7;

  localparam logic [6:0] c_OPC_OP    = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt;
  logic            w_legal;
  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_rd;
  logic            w_rd_we;
  logic            w_load;

  logic            r_valid;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic            r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u  = {in_instr[31:12], 12'b0};
  assign w_shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};

  always_comb begin
    w_legal = 1'b0;
    w_op    = c_ALU_ADD;
    w_a     = '0;
    w_b     = '0;
    case (w_opcode)
      c_OPC_OP: begin
        w_a = in_rs1_data;
        w_b = in_rs2_data;
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_ADD; end
            else if (w_funct7 == c_F7_ALT) begin w_legal = 1'b1; w_op = c_ALU_SUB; end
          end
          3'b001: if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_SLL; end
          3'b100: if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_XOR; end
          3'b110: if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_OR;  end
          3'b111: if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_AND; end
          3'b101: begin
            if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_SRL; end
            else if (w_funct7 == c_F7_ALT) begin w_legal = 1'b1; w_op = c_ALU_SRA; end
          end
          default: ;
        endcase
      end
      c_OPC_OPIMM: begin
        w_a = in_rs1_data;
        w_b = w_imm_i;
        case (w_funct3)
          3'b000: begin w_legal = 1'b1; w_op = c_ALU_ADD; end
          3'b100: begin w_legal = 1'b1; w_op = c_ALU_XOR; end
          3'b110: begin w_legal = 1'b1; w_op = c_ALU_OR;  end
          3'b111: begin w_legal = 1'b1; w_op = c_ALU_AND; end
          3'b001: begin
            w_b = w_shamt;
            if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_SLL; end
          end
          3'b101: begin
            // Shift immediates carry funct7 in imm[11:5]; only shamt reaches B.
            w_b = w_shamt;
            if (w_funct7 == c_F7_ZERO) begin w_legal = 1'b1; w_op = c_ALU_SRL; end
            else if (w_funct7 == c_F7_ALT) begin w_legal = 1'b1; w_op = c_ALU_SRA; end
          end
          default: ;
        endcase
      end
      c_OPC_LUI:   begin w_legal = 1'b1; w_a = '0;    w_b = w_imm_u; end
      c_OPC_AUIPC: begin w_legal = 1'b1; w_a = in_pc; w_b = w_imm_u; end
      default: ;
    endcase
    if (!w_legal) begin
      w_op = c_ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  assign w_rd    = w_legal ? in_instr[11:7] : 5'd0;
  assign w_rd_we = w_legal && (in_instr[11:7] != 5'd0);

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_op      <= c_ALU_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_op      <= w_op;
      r_a       <= w_a;
      r_b       <= w_b;
      r_rd      <= w_rd;
      r_rd_we   <= w_rd_we;
      r_illegal <= !w_legal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // A flushed entry never counts, even if EX is ready in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_valid && out_ready && !flush) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid  = r_valid;
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rd         = r_rd;
  assign rd_we      = r_rd_we;
  assign illegal    = r_illegal;
  assign issued_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_alu_issue
// Purpose : Self-checking bench for id_alu_issue (vector table, corner
//           sequences, randomized traffic against a reference model).
// Revision: 1.0  initial release
// ============================================================================
module tb_id_alu_issue;

  localparam int CNT_W = 32;
  localparam logic [3:0] E_ADD = 4'd0, E_SUB = 4'd1, E_SLL = 4'd2, E_XOR = 4'd3,
                         E_SRL = 4'd4, E_SRA = 4'd5, E_OR  = 4'd6, E_AND = 4'd7;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, out_valid, out_ready, rd_we, illegal;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic [CNT_W-1:0] issued_cnt;

  id_alu_issue #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .rd(rd), .rd_we(rd_we), .illegal(illegal), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } dec_t;

  localparam dec_t D_RESET = '{op: 4'd0, a: 32'd0, b: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b0};

  function automatic logic [3:0] op_of_f3(input logic [2:0] f3);
    case (f3)
      3'd1:    return E_SLL;
      3'd4:    return E_XOR;
      3'd5:    return E_SRL;
      3'd6:    return E_OR;
      3'd7:    return E_AND;
      default: return E_ADD;
    endcase
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
    dec_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic ok;
    f7 = ins[31:25];
    f3 = ins[14:12];
    ok = 1'b0;
    d  = '{op: E_ADD, a: 32'd0, b: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b1};
    if (ins[6:0] == 7'h33) begin
      d.a = r1; d.b = r2;
      if (f3 != 3'd2 && f3 != 3'd3) begin
        if (f7 == 7'h00) begin ok = 1'b1; d.op = op_of_f3(f3); end
        else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; d.op = E_SUB; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; d.op = E_SRA; end
      end
    end else if (ins[6:0] == 7'h13) begin
      d.a = r1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        d.b = 32'(ins[24:20]);
        if (f7 == 7'h00) begin ok = 1'b1; d.op = op_of_f3(f3); end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; d.op = E_SRA; end
      end else if (f3 != 3'd2 && f3 != 3'd3) begin
        d.b = 32'($signed(ins[31:20]));
        ok = 1'b1; d.op = op_of_f3(f3);
      end
    end else if (ins[6:0] == 7'h37) begin
      ok = 1'b1; d.a = 32'd0; d.b = ins & 32'hFFFF_F000;
    end else if (ins[6:0] == 7'h17) begin
      ok = 1'b1; d.a = pc; d.b = ins & 32'hFFFF_F000;
    end
    if (ok) begin
      d.ill = 1'b0; d.rd = ins[11:7]; d.we = (ins[11:7] != 5'd0);
    end else begin
      d = '{op: E_ADD, a: 32'd0, b: 32'd0, rd: 5'd0, we: 1'b0, ill: 1'b1};
    end
    return d;
  endfunction

  logic        m_v;
  dec_t        m_d;
  logic [31:0] m_cnt;

  task automatic check_fields(input dec_t e);
    chk("alu_op", alu_op, e.op);
    chk("alu_a", alu_a, e.a);
    chk("alu_b", alu_b, e.b);
    chk("rd", rd, e.rd);
    chk("rd_we", rd_we, e.we);
    chk("illegal", illegal, e.ill);
  endtask

  // One clock with the currently driven inputs; model advances alongside.
  task automatic step();
    logic rdy;
    #1;
    rdy = !m_v || out_ready;
    chk("in_ready", in_ready, rdy);
    if (reset) begin
      m_v = 1'b0; m_d = D_RESET; m_cnt = 0;
    end else begin
      if (m_v && out_ready && !flush) m_cnt = m_cnt + 1;
      if (flush) m_v = 1'b0;
      else if (in_valid && rdy) begin
        m_v = 1'b1;
        m_d = ref_dec(in_instr, in_pc, in_rs1_data, in_rs2_data);
      end else if (out_ready) m_v = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_v);
    chk("issued_cnt", issued_cnt, m_cnt);
    if (m_v) check_fields(m_d);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  typedef struct {
    logic [31:0] ins, pc, r1, r2;
    dec_t        e;
  } vec_t;

  vec_t tbl[12];
  logic [31:0] saved_cnt;

  initial begin
    tbl[0]  = '{32'h002081B3, 32'h0,    32'd5,        32'd7,   '{E_ADD, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0}};
    tbl[1]  = '{32'h40335293, 32'h0,    32'h80000000, 32'd9,   '{E_SRA, 32'h80000000, 32'd3,        5'd5, 1'b1, 1'b0}};
    tbl[2]  = '{32'hFFF00093, 32'h0,    32'd0,        32'd1,   '{E_ADD, 32'd0,        32'hFFFFFFFF, 5'd1, 1'b1, 1'b0}};
    tbl[3]  = '{32'h12345137, 32'h0,    32'hDEAD,     32'hBEEF,'{E_ADD, 32'd0,        32'h12345000, 5'd2, 1'b1, 1'b0}};
    tbl[4]  = '{32'h003120B3, 32'h0,    32'd4,        32'd5,   '{E_ADD, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1}};
    tbl[5]  = '{32'h00012083, 32'h0,    32'd4,        32'd5,   '{E_ADD, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1}};
    tbl[6]  = '{32'h403100B3, 32'h0,    32'd10,       32'd3,   '{E_SUB, 32'd10,       32'd3,        5'd1, 1'b1, 1'b0}};
    tbl[7]  = '{32'hABCDE217, 32'h1000, 32'd1,        32'd2,   '{E_ADD, 32'h1000,     32'hABCDE000, 5'd4, 1'b1, 1'b0}};
    tbl[8]  = '{32'h00208033, 32'h0,    32'd1,        32'd2,   '{E_ADD, 32'd1,        32'd2,        5'd0, 1'b0, 1'b0}};
    tbl[9]  = '{32'h4020C1B3, 32'h0,    32'd1,        32'd2,   '{E_ADD, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1}};
    tbl[10] = '{32'h01F09093, 32'h0,    32'h0F0F0F0F, 32'd2,   '{E_SLL, 32'h0F0F0F0F, 32'd31,       5'd1, 1'b1, 1'b0}};
    tbl[11] = '{32'h8001F113, 32'h0,    32'h12345678, 32'd2,   '{E_AND, 32'h12345678, 32'hFFFFF800, 5'd2, 1'b1, 1'b0}};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_v = 1'b0; m_d = D_RESET; m_cnt = 0;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset issued_cnt", issued_cnt, 32'd0);
    chk("reset in_ready", in_ready, 1'b1);
    check_fields(D_RESET);

    // Vector table, back-to-back at full throughput.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].ins, tbl[i].pc, tbl[i].r1, tbl[i].r2);
      step();
      chk($sformatf("tbl%0d valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d op", i), alu_op, tbl[i].e.op);
      chk($sformatf("tbl%0d a", i), alu_a, tbl[i].e.a);
      chk($sformatf("tbl%0d b", i), alu_b, tbl[i].e.b);
      chk($sformatf("tbl%0d rd", i), rd, tbl[i].e.rd);
      chk($sformatf("tbl%0d rd_we", i), rd_we, tbl[i].e.we);
      chk($sformatf("tbl%0d illegal", i), illegal, tbl[i].e.ill);
      chk($sformatf("tbl%0d cnt", i), issued_cnt, 32'(i));
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("drain valid", out_valid, 1'b0);
    chk("drain cnt", issued_cnt, 32'd12);

    // Stall for three cycles with a new instruction waiting.
    drive(1'b1, tbl[0].ins, 32'h0, 32'd5, 32'd7);
    step();
    saved_cnt = issued_cnt;
    out_ready = 1'b0;
    drive(1'b1, tbl[6].ins, 32'h0, 32'd10, 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall in_ready", in_ready, 1'b0);
      chk("stall a", alu_a, 32'd5);
      chk("stall op", alu_op, E_ADD);
      chk("stall cnt", issued_cnt, saved_cnt);
    end
    out_ready = 1'b1;
    step();
    chk("release op", alu_op, E_SUB);
    chk("release cnt", issued_cnt, saved_cnt + 1);

    // Flush while holding a stalled entry, incoming instruction dropped.
    out_ready = 1'b0;
    step();
    saved_cnt = issued_cnt;
    flush = 1'b1;
    drive(1'b1, tbl[3].ins, 32'h0, 32'd0, 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("flush valid", out_valid, 1'b0);
    chk("flush cnt", issued_cnt, saved_cnt);
    // Flush coinciding with an output handshake must not count it.
    out_ready = 1'b1;
    drive(1'b1, tbl[0].ins, 32'h0, 32'd5, 32'd7);
    step();
    saved_cnt = issued_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush hs valid", out_valid, 1'b0);
    chk("flush hs cnt", issued_cnt, saved_cnt);

    // Reset in the middle of a stall.
    step();
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid reset valid", out_valid, 1'b0);
    chk("mid reset cnt", issued_cnt, 32'd0);
    check_fields(D_RESET);
    out_ready = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        2: ins[6:0] = 7'h37;
        3: ins[6:0] = 7'h17;
        4: ins[6:0] = 7'h03;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      drive(($urandom % 4) != 0, ins, $urandom, $urandom, $urandom);
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
